rd_cell_addr: RTL and testbench
===============================

# rd_cell_addr

Module `rd_cell` is the per-column read-address cell of the LDPC decoder read-address generator. Thirty-six instances share one base counter, and each instance holds its own constant offset triple. Each cycle the cell adds one of three 8-bit circulant offsets to the shared base address and registers the sum as the column memory's read address. A 2-bit `cycle` phase selects which offset is used.

## Interface
- `A_WID`, default 8: address width. The offset bus is 3*`A_WID`.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset_n`  input  1  synchronous, active-high reset. The name is retained from the codebase; 1 means reset is asserted. It is sampled on the `clk` rising edge only.
- `en`  input  1  read enable, driven from `fsm[2]`.
- `cycle`  input  2  sub-cycle phase, 0..3.
- `base_addr`  input  `A_WID`  shared row counter. It advances after each `cycle`==3.
- `addr_offset`  input  3*`A_WID`  packed offsets, held static per instance.
  - off0 = [`A_WID`-1:0]
  - off1 = [2*`A_WID`-1:`A_WID`]
  - off2 = [3*`A_WID`-1:2*`A_WID`]
- `rd_addr`  output  `A_WID`  registered read address.

## Operation
- There is a single register, `rd_addr`. There is no other state and no state machine.
- The next-state rule is evaluated at each `clk` rising edge, in priority order:
  1. `reset_n`=1: `rd_addr` <= 0.
  2. `en`=0: `rd_addr` <= 0.
  3. `en`=1 and `cycle`=0: `rd_addr` <= `base_addr` + off0.
  4. `en`=1 and `cycle`=1: `rd_addr` <= `base_addr` + off1.
  5. `en`=1 and `cycle`=2: `rd_addr` <= `base_addr` + off2.
  6. `en`=1 and `cycle`=3: `rd_addr` holds its value (idle phase while the base counter advances).
- Arithmetic is unsigned, modulo 2^`A_WID`. The carry out is discarded.
  - An offset of 255 therefore acts as −1 for `A_WID`=8.
  - Example: base 3 + offset 255 = 2. No saturation and no error flag.
- Offsets are treated as arbitrary inputs, not hard-wired constants. A change to `addr_offset` takes effect at the next qualifying edge.
- The block is purely combinational-add plus one register. It has no handshake, no backpressure and no valid output.

## Timing
- Latency is 1 clock. The output after edge N reflects `en`, `cycle`, `base_addr` and `addr_offset` sampled at edge N.
- `rd_addr` is 0 after reset and stays 0 while `reset_n`=1.
- `rd_addr` is 0 in the cycle after `en` deasserts.
- Reset asserted mid-sequence clears the output at the next edge, overriding `en`/`cycle`.
- On reset release with `en`=1, the first address appears one edge later.
- Holding `cycle`=3 for several clocks keeps the last computed address.
- With `en` first asserted and `cycle`=3, the output stays 0 until the next `cycle`=0..2 edge.
- `base_addr` wrap from 255 to 0 needs no special handling; the sum simply wraps.

## Test plan
- **Reset:** `reset_n`=1 for 3 clocks with `en`=1, `cycle`=0, `base_addr`=10, offsets {0,0,0} -> `rd_addr`=0 throughout. After release, `rd_addr`=10 one clock later.
- **Phase sweep:** offsets {off2=0, off1=129, off0=65}, `base_addr`=5, `cycle` stepping 0,1,2,3 -> `rd_addr` = 70, 134, 5, then holds at 5.
- **Wrap-around:** offsets {0,255,0}, `base_addr`=0 then `cycle`=1 -> 255. With `base_addr`=200, off1=255 -> 199. With `base_addr`=255, off0=1 -> 0.
- **Enable drop:** `en` falling from 1 to 0 mid-phase while `rd_addr`=134 -> 0 at the next edge. Re-assert `en` with `cycle`=0 -> `base_addr`+off0 after one clock.
- **Full sequence:** `rd_counter`-style base 0..3, incrementing after each `cycle`=3, with offsets {254,200,0} -> per row (cycles 0,1,2):
  - row 0: 0, 200, 254
  - row 1: 1, 201, 255
  - row 2: 2, 202, 0
  - row 3: 3, 203, 1
- **Reset mid-operation:** assert `reset_n` at `cycle`=1 with `rd_addr`≠0 -> 0 at the next edge, regardless of `en`.

Source files
------------

// File: rtl/rd_cell_addr_if.sv
// Signal bundle for one per-column read-address cell: shared base counter,
// per-instance offset triple, phase select and the registered read address.
interface rd_cell_addr_if #(
    parameter int A_WID = 8
);
    // No handshake: the cell samples en/cycle/base_addr/addr_offset on every
    // clk rising edge, and rd_addr is valid every cycle with no backpressure.
    logic                 en;
    logic [1:0]           cycle;
    logic [A_WID-1:0]     base_addr;
    logic [3*A_WID-1:0]   addr_offset;
    logic [A_WID-1:0]     rd_addr;

    modport master (
        output en,
        output cycle,
        output base_addr,
        output addr_offset,
        input  rd_addr
    );

    modport slave (
        input  en,
        input  cycle,
        input  base_addr,
        input  addr_offset,
        output rd_addr
    );
endinterface

// File: rtl/rd_cell_addr.sv
// Per-column LDPC read-address cell: registers base_addr plus the offset chosen
// by the cycle phase; phase 3 holds while the shared base counter advances.
module rd_cell_addr #(
    parameter int A_WID = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    rd_cell_addr_if.slave bus
);

    logic [A_WID-1:0] off0;
    logic [A_WID-1:0] off1;
    logic [A_WID-1:0] off2;
    logic [A_WID-1:0] sel_off;
    logic [A_WID-1:0] sum;
    logic [A_WID-1:0] rd_addr_q;
    logic [A_WID-1:0] rd_addr_d;

    assign off0 = bus.addr_offset[A_WID-1:0];
    assign off1 = bus.addr_offset[2*A_WID-1:A_WID];
    assign off2 = bus.addr_offset[3*A_WID-1:2*A_WID];

    always_comb begin
        sel_off = off0;
        case (bus.cycle)
            2'd0:    sel_off = off0;
            2'd1:    sel_off = off1;
            2'd2:    sel_off = off2;
            default: sel_off = off0;
        endcase
    end

    // Carry out is dropped on purpose: an offset of all-ones acts as -1.
    assign sum = bus.base_addr + sel_off;

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (!bus.en) begin
            rd_addr_d = '0;
        end else if (bus.cycle != 2'd3) begin
            rd_addr_d = sum;
        end
    end

    // reset_n keeps its historical name but is active-high.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            rd_addr_q <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
        end
    end

    assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_rd_cell_addr.sv
// Directed bench for rd_cell_addr: a driver pushes hand-computed addresses into
// a queue and a monitor pops one per clock after the rising edge.
module tb_rd_cell_addr;

    logic clk;
    logic reset_n;

    rd_cell_addr_if #(.A_WID(8)) bus ();

    rd_cell_addr #(.A_WID(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_pass;
    int         n_total;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset_n         = 1'b1;
        bus.en          = 1'b0;
        bus.cycle       = 2'd0;
        bus.base_addr   = 8'd0;
        bus.addr_offset = 24'd0;
    end

    // driver: inputs change on the falling edge, expectation for the next rising edge
    task automatic drive(input logic rst, input logic e, input logic [1:0] c,
                         input logic [7:0] b, input logic [23:0] off,
                         input logic [7:0] exp, input string nm);
        @(negedge clk);
        reset_n         = rst;
        bus.en          = e;
        bus.cycle       = c;
        bus.base_addr   = b;
        bus.addr_offset = off;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    initial begin
        n_pass  = 0;
        n_total = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_total++;
                if (bus.rd_addr === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: rd_addr=%0d expected=%0d at %0t", nm, bus.rd_addr, e, $time);
                end
            end
        end
    end

    logic [7:0] row_exp [4][3];

    initial begin
        row_exp[0][0] = 8'd0; row_exp[0][1] = 8'd200; row_exp[0][2] = 8'd254;
        row_exp[1][0] = 8'd1; row_exp[1][1] = 8'd201; row_exp[1][2] = 8'd255;
        row_exp[2][0] = 8'd2; row_exp[2][1] = 8'd202; row_exp[2][2] = 8'd0;
        row_exp[3][0] = 8'd3; row_exp[3][1] = 8'd203; row_exp[3][2] = 8'd1;

        // reset held with en=1
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 2'd0, 8'd10, 24'd0, 8'd0, "reset_hold");
        drive(1'b0, 1'b1, 2'd0, 8'd10, 24'd0, 8'd10, "reset_release");

        // phase sweep: {off2=0, off1=129, off0=65}
        drive(1'b0, 1'b1, 2'd0, 8'd5, {8'd0, 8'd129, 8'd65}, 8'd70,  "phase0");
        drive(1'b0, 1'b1, 2'd1, 8'd5, {8'd0, 8'd129, 8'd65}, 8'd134, "phase1");
        drive(1'b0, 1'b1, 2'd2, 8'd5, {8'd0, 8'd129, 8'd65}, 8'd5,   "phase2");
        drive(1'b0, 1'b1, 2'd3, 8'd6, {8'd0, 8'd129, 8'd65}, 8'd5,   "phase3_hold");
        drive(1'b0, 1'b1, 2'd3, 8'd6, {8'd0, 8'd129, 8'd65}, 8'd5,   "phase3_hold2");

        // enable drop mid-phase, then re-assert
        drive(1'b0, 1'b1, 2'd1, 8'd5, {8'd0, 8'd129, 8'd65}, 8'd134, "pre_drop");
        drive(1'b0, 1'b0, 2'd1, 8'd5, {8'd0, 8'd129, 8'd65}, 8'd0,   "en_drop");
        drive(1'b0, 1'b0, 2'd2, 8'd5, {8'd0, 8'd129, 8'd65}, 8'd0,   "en_low");
        drive(1'b0, 1'b1, 2'd0, 8'd9, {8'd0, 8'd129, 8'd65}, 8'd74,  "en_reassert");

        // wrap-around
        drive(1'b0, 1'b1, 2'd1, 8'd0,   {8'd0, 8'd255, 8'd0}, 8'd255, "wrap_0_m1");
        drive(1'b0, 1'b1, 2'd1, 8'd200, {8'd0, 8'd255, 8'd0}, 8'd199, "wrap_200_m1");
        drive(1'b0, 1'b1, 2'd0, 8'd255, {8'd0, 8'd0, 8'd1},   8'd0,   "wrap_255_p1");
        drive(1'b0, 1'b1, 2'd0, 8'd3,   {8'd0, 8'd0, 8'd255}, 8'd2,   "wrap_3_m1");
        drive(1'b0, 1'b1, 2'd2, 8'd255, {8'd255, 8'd0, 8'd0}, 8'd254, "wrap_off2");

        // full sequence with offsets {254,200,0}, base advancing after cycle 3
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++)
                drive(1'b0, 1'b1, 2'(c), 8'(r), {8'd254, 8'd200, 8'd0}, row_exp[r][c], "full_seq");
            drive(1'b0, 1'b1, 2'd3, 8'(r + 1), {8'd254, 8'd200, 8'd0}, row_exp[r][2], "full_seq_hold");
        end

        // en first asserted on cycle 3 keeps output at zero
        drive(1'b0, 1'b0, 2'd0, 8'd7, 24'd0, 8'd0, "en_off");
        drive(1'b0, 1'b1, 2'd3, 8'd7, 24'd0, 8'd0, "en_on_c3");
        drive(1'b0, 1'b1, 2'd0, 8'd7, 24'd0, 8'd7, "en_on_c0");

        // reset mid-operation overrides en/cycle
        drive(1'b0, 1'b1, 2'd1, 8'd10, {8'd254, 8'd200, 8'd0}, 8'd210, "pre_reset");
        drive(1'b1, 1'b1, 2'd1, 8'd10, {8'd254, 8'd200, 8'd0}, 8'd0,   "reset_mid");
        drive(1'b0, 1'b1, 2'd3, 8'd10, {8'd254, 8'd200, 8'd0}, 8'd0,   "release_c3");
        drive(1'b0, 1'b1, 2'd2, 8'd10, {8'd254, 8'd200, 8'd0}, 8'd8,   "release_c2");

        // offset change takes effect on the next qualifying edge
        drive(1'b0, 1'b1, 2'd0, 8'd10, {8'd254, 8'd200, 8'd50}, 8'd60, "offset_change");

        // drain with a bounded wait
        begin
            int waited;
            waited = 0;
            while (exp_q.size() > 0 && waited < 20) begin
                @(posedge clk);
                waited++;
            end
            #2;
            if (exp_q.size() > 0) begin
                n_total++;
                $display("FAIL drain: pending=%0d expected=0", exp_q.size());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
